// File: rtl/seq_bit_serializer_if.sv
// ---------------------------------------------------------------------------
// seq_bit_serializer_if
//
// Purpose: bundles the parallel-load handshake and the serial output stream
//          of seq_bit_serializer into one interface.
//
// Signals:
//   data_in     [WIDTH-1:0]  parallel word offered by the producer
//   load_valid               producer has a word on data_in
//   load_ready               serializer can take a word this cycle
//   abort                    synchronous flush of the word in flight
//   bit_out                  serial stream bit, MSB first
//   bit_valid                bit_out carries a stream bit
//
// Handshake: a word moves on a rising clk edge where load_valid and
// load_ready are both 1. load_valid may be raised or dropped at any time;
// load_ready is combinational and may fall in the same cycle abort rises.
// bit_out/bit_valid form a push-only stream with no back-pressure.
//
// Modports:
//   master  producer / stream consumer side (drives data_in, load_valid, abort)
//   slave   the serializer itself
// ---------------------------------------------------------------------------
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             abort;
  logic             bit_out;
  logic             bit_valid;

  modport master (
    output data_in,
    output load_valid,
    output abort,
    input  load_ready,
    input  bit_out,
    input  bit_valid
  );

  modport slave (
    input  data_in,
    input  load_valid,
    input  abort,
    output load_ready,
    output bit_out,
    output bit_valid
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// ---------------------------------------------------------------------------
// seq_bit_serializer
//
// Purpose: accepts a WIDTH-bit word through a valid/ready handshake and
//          streams it MSB first, one bit per clock, to a downstream sequence
//          detector. Back-to-back words stream without an idle gap.
//
// Optional feature: define SER_PARITY_EN to append one even-parity bit
//          (XOR of all captured data bits) after bit 0 of every word.
//
// Ports:
//   clk      single clock, all state updates on the rising edge
//   rst_n    asynchronous active-low reset
//   bus      seq_bit_serializer_if.slave (data_in, load_valid, load_ready,
//            abort, bit_out, bit_valid)
//   state_o  current FSM state for observation:
//            0 = IDLE, 1 = SHIFT, 2 = PARITY (parity build only)
//
// Timing: the word accepted on edge N shows bit WIDTH-1 on bit_out during
// the cycle after edge N. load_ready is high in IDLE and in the final
// stream cycle of the current word, and is forced low while abort is high.
// ---------------------------------------------------------------------------
module seq_bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_bit_serializer_if.slave  bus,
  output logic [1:0]           state_o
);

  localparam int              CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_TOP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1
`ifdef SER_PARITY_EN
    ,
    S_PARITY = 2'd2
`endif
  } state_t;

  state_t           state_q;
  // Holds the bits not yet shown on bit_out, left-aligned; the next bit to
  // present is always shreg_q[WIDTH-1].
  logic [WIDTH-1:0] shreg_q;
  // Index of the data bit currently on bit_out (WIDTH-1 down to 0).
  logic [CW-1:0]    cnt_q;
  logic             bit_out_q;
  logic             bit_valid_q;
`ifdef SER_PARITY_EN
  logic             parity_q;
`endif

  logic             last_cycle;
  logic             load_ready;
  logic             accept;

  // The final stream cycle is where the next word may be taken so that it
  // begins on the very next cycle.
`ifdef SER_PARITY_EN
  assign last_cycle = (state_q == S_PARITY);
`else
  assign last_cycle = (state_q == S_SHIFT) && (cnt_q == '0);
`endif

  assign load_ready = ~bus.abort & ((state_q == S_IDLE) | last_cycle);
  assign accept     = bus.load_valid & load_ready;

  // -------------------------------------------------------------------------
  // FSM with registered stream outputs. Priority: reset, abort, accept,
  // then normal stepping through the word.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else if (bus.abort) begin
      // Flush: remaining bits are discarded and the stream goes quiet now.
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else if (accept) begin
      // MSB goes straight to the output register; the rest waits in shreg_q.
      state_q     <= S_SHIFT;
      bit_out_q   <= bus.data_in[WIDTH-1];
      bit_valid_q <= 1'b1;
      shreg_q     <= {bus.data_in[WIDTH-2:0], 1'b0};
      cnt_q       <= CNT_TOP;
`ifdef SER_PARITY_EN
      parity_q    <= ^bus.data_in;
`endif
    end else begin
      unique case (state_q)
        S_SHIFT: begin
          if (cnt_q != '0) begin
            bit_out_q <= shreg_q[WIDTH-1];
            shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
            cnt_q     <= cnt_q - 1'b1;
          end else begin
`ifdef SER_PARITY_EN
            state_q   <= S_PARITY;
            bit_out_q <= parity_q;
`else
            state_q     <= S_IDLE;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
`endif
          end
        end
`ifdef SER_PARITY_EN
        S_PARITY: begin
          state_q     <= S_IDLE;
          bit_out_q   <= 1'b0;
          bit_valid_q <= 1'b0;
          parity_q    <= 1'b0;
        end
`endif
        default: begin
          state_q     <= S_IDLE;
          bit_out_q   <= 1'b0;
          bit_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.bit_out    = bit_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign state_o        = state_q;

  // -------------------------------------------------------------------------
  // Structural invariants of the stream.
  // -------------------------------------------------------------------------
  a_quiet_when_invalid : assert property (
    @(posedge clk) disable iff (!rst_n) !bit_valid_q |-> !bit_out_q
  );

  a_cnt_in_range : assert property (
    @(posedge clk) disable iff (!rst_n) cnt_q <= CNT_TOP
  );

  a_idle_is_quiet : assert property (
    @(posedge clk) disable iff (!rst_n) (state_q == S_IDLE) |-> !bit_valid_q
  );

endmodule

// File: tb/tb_seq_bit_serializer.sv
module tb_seq_bit_serializer;

  localparam int WIDTH = 8;

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  seq_bit_serializer_if #(.WIDTH(WIDTH)) bus ();

  seq_bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------------------------------------------------------- counters
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // The stream is a queue of bits still owed to the consumer. A word can be
  // taken only when nothing is owed beyond the bit currently showing.
  logic [0:0] exp_q[$];
  logic       m_val = 1'b0;
  logic       m_bit = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_val = 1'b0;
      m_bit = 1'b0;
    end else if (bus.abort) begin
      exp_q.delete();
      m_val = 1'b0;
      m_bit = 1'b0;
    end else begin
      if (bus.load_valid && exp_q.size() == 0) begin
        for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(bus.data_in[i]);
`ifdef SER_PARITY_EN
        exp_q.push_back(^bus.data_in);
`endif
      end
      if (exp_q.size() > 0) begin
        m_bit = exp_q.pop_front();
        m_val = 1'b1;
      end else begin
        m_bit = 1'b0;
        m_val = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (chk_en) begin
      check("bit_valid", 32'(bus.bit_valid), 32'(m_val));
      check("bit_out", 32'(bus.bit_out), 32'(m_bit));
      check("load_ready", 32'(bus.load_ready), 32'(!bus.abort && exp_q.size() == 0));
    end
  end

  // ---------------------------------------------------------------- observer
  bit          rec = 1'b0;
  int          obs_cyc, obs_n, obs_first, obs_last;
  logic [31:0] obs_word, obs_rdy;

  always @(negedge clk) begin
    if (rec) begin
      obs_cyc++;
      if (bus.bit_valid) begin
        obs_word = {obs_word[30:0], bus.bit_out};
        obs_rdy  = {obs_rdy[30:0], bus.load_ready};
        if (obs_n == 0) obs_first = obs_cyc;
        obs_last = obs_cyc;
        obs_n++;
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rec_start();
    obs_cyc   = 0;
    obs_n     = 0;
    obs_first = 0;
    obs_last  = 0;
    obs_word  = '0;
    obs_rdy   = '0;
    rec       = 1'b1;
  endtask

  task automatic check_contig(input string name);
    check(name, 32'(obs_last - obs_first + 1), 32'(obs_n));
  endtask

  logic [31:0] tbl;

  initial begin
    bus.data_in    = '0;
    bus.load_valid = 1'b0;
    bus.abort      = 1'b0;

    // reset
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
    check("rst_bit_out", 32'(bus.bit_out), 32'd0);
    check("rst_load_ready", 32'(bus.load_ready), 32'd1);
    check("rst_state", 32'(state_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // single word 1001_0110
    rec_start();
    bus.load_valid = 1'b1;
    bus.data_in    = 8'b1001_0110;
    tick();
    bus.load_valid = 1'b0;
    bus.data_in    = 8'($urandom);
    repeat (11) tick();
    rec = 1'b0;
`ifndef SER_PARITY_EN
    check("w96_count", 32'(obs_n), 32'd8);
    check("w96_bits", obs_word, 32'h96);
    check("w96_ready", obs_rdy, 32'h01);
    check("w96_first_cycle", 32'(obs_first), 32'd2);
`endif
    check_contig("w96_contig");

    // held load_valid: A5 then 3C back to back
    rec_start();
    bus.load_valid = 1'b1;
    bus.data_in    = 8'hA5;
    tick();
    bus.data_in = 8'h3C;
`ifdef SER_PARITY_EN
    repeat (9) tick();
`else
    repeat (8) tick();
`endif
    bus.load_valid = 1'b0;
    repeat (12) tick();
    rec = 1'b0;
`ifndef SER_PARITY_EN
    check("b2b_count", 32'(obs_n), 32'd16);
    check("b2b_bits", obs_word, 32'hA53C);
    check("b2b_ready", obs_rdy, 32'h0101);
`endif
    check_contig("b2b_contig");

    // abort during the 3rd bit of FF
    rec_start();
    bus.load_valid = 1'b1;
    bus.data_in    = 8'hFF;
    tick();
    bus.load_valid = 1'b0;
    repeat (2) tick();
    bus.abort = 1'b1;
    #1;
    check("abort_ready_low", 32'(bus.load_ready), 32'd0);
    tick();
    bus.abort = 1'b0;
    #1;
    check("abort_bit_valid", 32'(bus.bit_valid), 32'd0);
    check("abort_bit_out", 32'(bus.bit_out), 32'd0);
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_ready_back", 32'(bus.load_ready), 32'd1);
    repeat (4) tick();
    rec = 1'b0;
    check("abort_count", 32'(obs_n), 32'd3);
    check("abort_bits", obs_word, 32'h7);

    // load attempts in cycles 2..7 are ignored
    rec_start();
    bus.load_valid = 1'b1;
    bus.data_in    = 8'hC3;
    tick();
    bus.load_valid = 1'b0;
    tick();
    for (int i = 2; i <= 7; i++) begin
      bus.load_valid = 1'b1;
      bus.data_in    = 8'($urandom);
      tick();
    end
    bus.load_valid = 1'b0;
    repeat (6) tick();
    rec = 1'b0;
`ifndef SER_PARITY_EN
    check("ign_count", 32'(obs_n), 32'd8);
    check("ign_bits", obs_word, 32'hC3);
    check("ign_ready", obs_rdy, 32'h01);
`endif
    check_contig("ign_contig");

    // reset between edges mid-word, then a clean 81
    rec_start();
    bus.load_valid = 1'b1;
    bus.data_in    = 8'h5A;
    tick();
    bus.load_valid = 1'b0;
    repeat (3) tick();
    #3;
    rst_n          = 1'b0;
    bus.load_valid = 1'b1;
    bus.data_in    = 8'hFF;
    #1;
    check("rst_mid_bit_valid", 32'(bus.bit_valid), 32'd0);
    check("rst_mid_bit_out", 32'(bus.bit_out), 32'd0);
    check("rst_mid_ready", 32'(bus.load_ready), 32'd1);
    repeat (2) tick();
    bus.load_valid = 1'b0;
    rst_n          = 1'b1;
    tick();
    check("rst_no_accept", 32'(bus.bit_valid), 32'd0);
    rec_start();
    bus.load_valid = 1'b1;
    bus.data_in    = 8'h81;
    tick();
    bus.load_valid = 1'b0;
    repeat (11) tick();
    rec = 1'b0;
`ifndef SER_PARITY_EN
    check("w81_count", 32'(obs_n), 32'd8);
    check("w81_bits", obs_word, 32'h81);
`endif
    check_contig("w81_contig");

    // four words back to back from a table
    tbl = 32'h00FF_0180;
    rec_start();
    bus.load_valid = 1'b1;
    for (int w = 0; w < 4; w++) begin
      bus.data_in = tbl[31 - 8*w -: 8];
      if (w == 0) tick();
`ifdef SER_PARITY_EN
      else repeat (9) tick();
`else
      else repeat (8) tick();
`endif
    end
    bus.load_valid = 1'b0;
    repeat (12) tick();
    rec = 1'b0;
`ifndef SER_PARITY_EN
    check("tbl_count", 32'(obs_n), 32'd32);
    check("tbl_bits", obs_word, 32'h00FF_0180);
`endif
    check_contig("tbl_contig");

`ifdef SER_PARITY_EN
    // parity: 1001_0111 has five ones, so the appended bit is 1
    rec_start();
    bus.load_valid = 1'b1;
    bus.data_in    = 8'b1001_0111;
    tick();
    bus.load_valid = 1'b0;
    repeat (12) tick();
    rec = 1'b0;
    check("par_count", 32'(obs_n), 32'd9);
    check("par_bits", obs_word, 32'h12F);
    check("par_ready", obs_rdy, 32'h001);
`endif

    // mixed traffic with occasional aborts, checked by the scoreboard
    for (int c = 0; c < 300; c++) begin
      bus.load_valid = ($urandom_range(0, 3) != 0);
      bus.data_in    = 8'($urandom);
      bus.abort      = ($urandom_range(0, 19) == 0);
      tick();
    end
    bus.abort      = 1'b0;
    bus.load_valid = 1'b0;
    repeat (12) tick();
    check("drain_idle", 32'(state_o), 32'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
